// File: rtl/reg_scoreboard.sv
// Register-hazard scoreboard: one busy bit per architectural register, RAW/WAW
// stall generation and drain status for the issue stage.
module reg_scoreboard #(
    parameter int NUM_REGS  = 32,
    parameter int ADDR_W    = 5,
    parameter int WB_BYPASS = 1,
    parameter int CNT_W     = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                issue_valid,
    input  logic [ADDR_W-1:0]   issue_dst,
    input  logic [ADDR_W-1:0]   issue_src1,
    input  logic [ADDR_W-1:0]   issue_src2,
    input  logic                issue_use_src1,
    input  logic                issue_use_src2,
    input  logic                issue_writes,
    input  logic                wb_valid,
    input  logic [ADDR_W-1:0]   wb_dst,
    input  logic                flush,
    output logic                stall,
    output logic [NUM_REGS-1:0] busy_mask,
    output logic [CNT_W-1:0]    pending_count,
    output logic                idle,
    output logic                wb_error
);

    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [NUM_REGS-1:0] clr, blk;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                idle_q, idle_d;
    logic                err_q, err_d;
    logic                src1_blk, src2_blk, dst_blk, wb_tgt_busy;
    logic                hazard, accept;

    // A register still blocks issue unless its write retires this very cycle
    // and bypass is enabled.
    always_comb begin
        clr = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            clr[i] = wb_valid && (wb_dst == ADDR_W'(i)) && busy_q[i] && (WB_BYPASS != 0);
        end
        blk = busy_q & ~clr;
    end

    always_comb begin
        src1_blk    = 1'b0;
        src2_blk    = 1'b0;
        dst_blk     = 1'b0;
        wb_tgt_busy = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (issue_src1 == ADDR_W'(i)) src1_blk = blk[i];
            if (issue_src2 == ADDR_W'(i)) src2_blk = blk[i];
            if (issue_dst == ADDR_W'(i))  dst_blk  = blk[i];
            if (wb_dst == ADDR_W'(i))     wb_tgt_busy = busy_q[i];
        end
    end

    assign hazard = issue_valid && ((issue_use_src1 && src1_blk) ||
                                    (issue_use_src2 && src2_blk) ||
                                    (issue_writes && dst_blk));
    assign stall  = hazard;
    assign accept = issue_valid && !hazard && !flush;

    // Writeback clears first, then an accepted issue sets, so a same-cycle
    // retire/re-issue of one register leaves it busy.
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (flush) begin
                busy_d[i] = 1'b0;
            end else begin
                if (wb_valid && (wb_dst == ADDR_W'(i)))
                    busy_d[i] = 1'b0;
                if (accept && issue_writes && (issue_dst == ADDR_W'(i)))
                    busy_d[i] = 1'b1;
            end
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        err_d = err_q;
        if (!flush && wb_valid && (wb_dst != '0) && !wb_tgt_busy)
            err_d = 1'b1;
    end

    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            cnt_d = cnt_d + CNT_W'(busy_d[i]);
        end
        idle_d = (busy_d == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= '0;
            cnt_q  <= '0;
            idle_q <= 1'b1;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            idle_q <= idle_d;
            err_q  <= err_d;
        end
    end

    assign busy_mask     = busy_q;
    assign pending_count = cnt_q;
    assign idle          = idle_q;
    assign wb_error      = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: bypass and non-bypass instances share stimulus and
// are compared every cycle against a per-instance busy-set model.
module tb_reg_scoreboard;

    logic       clk = 1'b0;
    logic       reset;
    logic       iv, iu1, iu2, iw, wv, fl;
    logic [4:0] idst, is1, is2, wd;

    logic        stall_w [2];
    logic [31:0] bm_w    [2];
    logic [5:0]  cnt_w   [2];
    logic        idle_w  [2];
    logic        err_w   [2];

    bit [31:0] m_busy [2];
    bit        m_err  [2];
    int        n_chk  = 0;
    int        n_pass = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        reg_scoreboard #(.NUM_REGS(32), .ADDR_W(5), .WB_BYPASS(g == 0 ? 1 : 0), .CNT_W(6)) dut (
            .clk(clk), .reset(reset),
            .issue_valid(iv), .issue_dst(idst), .issue_src1(is1), .issue_src2(is2),
            .issue_use_src1(iu1), .issue_use_src2(iu2), .issue_writes(iw),
            .wb_valid(wv), .wb_dst(wd), .flush(fl),
            .stall(stall_w[g]), .busy_mask(bm_w[g]), .pending_count(cnt_w[g]),
            .idle(idle_w[g]), .wb_error(err_w[g])
        );
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        else n_pass++;
    endtask

    // Does register r block issue in instance k this cycle?
    function automatic bit m_blocks(int k, int r);
        bit retiring = wv && (int'(wd) == r) && (k == 0);
        return m_busy[k][r] && !retiring;
    endfunction

    function automatic bit m_stall(int k);
        return iv && ((iu1 && m_blocks(k, is1)) || (iu2 && m_blocks(k, is2)) ||
                      (iw && m_blocks(k, idst)));
    endfunction

    function automatic int m_count(int k);
        int c = 0;
        for (int r = 0; r < 32; r++) c += m_busy[k][r];
        return c;
    endfunction

    task automatic check_regs(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s.busy%0d", tag, k), bm_w[k], m_busy[k]);
            chk($sformatf("%s.cnt%0d", tag, k), cnt_w[k], m_count(k));
            chk($sformatf("%s.idle%0d", tag, k), idle_w[k], m_busy[k] == 0);
            chk($sformatf("%s.err%0d", tag, k), err_w[k], m_err[k]);
        end
    endtask

    // Inputs are set; check stall, clock once, advance the model, check state.
    task automatic cycle(input string tag);
        bit [31:0] nb [2];
        bit        ne [2];
        #1;
        for (int k = 0; k < 2; k++) begin
            bit hz = m_stall(k);
            chk($sformatf("%s.stall%0d", tag, k), stall_w[k], hz);
            nb[k] = m_busy[k];
            ne[k] = m_err[k];
            if (fl) begin
                nb[k] = 0;
            end else begin
                if (wv) begin
                    if (wd != 0 && !m_busy[k][wd]) ne[k] = 1;
                    nb[k][wd] = 0;
                end
                if (iv && !hz && iw && idst != 0) nb[k][idst] = 1;
            end
        end
        @(posedge clk);
        #1;
        m_busy = nb;
        m_err  = ne;
        check_regs(tag);
    endtask

    task automatic drive(input bit v, input int d, input int s1, input int s2, input bit u1,
                         input bit u2, input bit w, input bit wbv, input int wbd, input bit f);
        iv = v; idst = 5'(d); is1 = 5'(s1); is2 = 5'(s2); iu1 = u1; iu2 = u2; iw = w;
        wv = wbv; wd = 5'(wbd); fl = f;
    endtask

    task automatic quiet();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic async_reset(input string tag);
        quiet();
        #2 reset = 1'b1;
        #1;
        m_busy[0] = 0; m_busy[1] = 0; m_err[0] = 0; m_err[1] = 0;
        check_regs(tag);
        #1 reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        quiet();
        #12;
        check_regs("por");
        reset = 1'b0;
        @(posedge clk); #1;

        // reset mid-run with r1,r2 busy
        drive(1, 1, 0, 0, 0, 0, 1, 0, 0, 0); cycle("set1");
        drive(1, 2, 0, 0, 0, 0, 1, 0, 0, 0); cycle("set2");
        chk("pre_rst_mask", bm_w[0], 32'h6);
        async_reset("midrst");
        chk("rst_mask", bm_w[0], 32'h0);

        // RAW on r1
        drive(1, 1, 0, 0, 0, 0, 1, 0, 0, 0); cycle("raw_i");
        drive(1, 3, 1, 0, 1, 0, 1, 0, 0, 0); cycle("raw_s");
        chk("raw_stall", stall_w[0], 1'b1);
        drive(1, 3, 1, 0, 1, 0, 1, 1, 1, 0);
        #1;
        chk("raw_byp_stall", stall_w[0], 1'b0);
        chk("raw_nobyp_stall", stall_w[1], 1'b1);
        cycle("raw_wb");
        drive(1, 3, 1, 0, 1, 0, 1, 0, 0, 0);
        #1;
        chk("raw_nobyp_late", stall_w[1], 1'b0);
        cycle("raw_late");
        async_reset("rst2");

        // immediate form, dst r0, wb r0
        drive(1, 1, 0, 0, 0, 0, 1, 0, 0, 0); cycle("imm_i");
        drive(1, 4, 0, 1, 0, 0, 1, 0, 0, 0); cycle("imm_u");
        drive(1, 0, 0, 0, 0, 0, 1, 0, 0, 0); cycle("r0_dst");
        chk("r0_mask", bm_w[0], 32'h12);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0); cycle("r0_wb");
        chk("r0_noerr", err_w[0], 1'b0);
        async_reset("rst3");

        // WAW and count
        drive(1, 2, 0, 0, 0, 0, 1, 0, 0, 0); cycle("waw_a");
        drive(1, 3, 0, 0, 0, 0, 1, 0, 0, 0); cycle("waw_b");
        chk("waw_cnt2", cnt_w[0], 6'd2);
        drive(1, 2, 0, 0, 0, 0, 1, 0, 0, 0); cycle("waw_st");
        chk("waw_stall", stall_w[0], 1'b1);
        drive(1, 2, 0, 0, 0, 0, 1, 1, 2, 0); cycle("waw_wb");
        chk("waw_cnt_byp", cnt_w[0], 6'd2);
        chk("waw_cnt_nobyp", cnt_w[1], 6'd1);
        async_reset("rst4");

        // flush with an issue in the same cycle, then stale wb
        drive(1, 1, 0, 0, 0, 0, 1, 0, 0, 0); cycle("fl_1");
        drive(1, 4, 0, 0, 0, 0, 1, 0, 0, 0); cycle("fl_4");
        drive(1, 5, 0, 0, 0, 0, 1, 0, 0, 0); cycle("fl_5");
        drive(1, 6, 0, 0, 0, 0, 1, 0, 0, 1); cycle("fl");
        chk("fl_mask", bm_w[0], 32'h0);
        chk("fl_idle", idle_w[0], 1'b1);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 4, 0); cycle("fl_wb");
        chk("fl_err", err_w[0], 1'b1);
        quiet(); cycle("fl_sticky");
        chk("fl_err_sticky", err_w[0], 1'b1);
        async_reset("rst5");

        // same-cycle retire and re-issue of r7
        drive(1, 7, 0, 0, 0, 0, 1, 0, 0, 0); cycle("sim_i");
        drive(1, 7, 0, 0, 0, 0, 1, 1, 7, 0); cycle("sim");
        chk("sim_bit7", bm_w[0][7], 1'b1);
        chk("sim_cnt", cnt_w[0], 6'd1);
        async_reset("rst6");

        // random traffic over r0..r7
        for (int n = 0; n < 600; n++) begin
            int r;
            iv   = ($urandom % 4) != 0;
            idst = 5'($urandom_range(0, 7));
            is1  = 5'($urandom_range(0, 7));
            is2  = 5'($urandom_range(0, 7));
            iu1  = $urandom % 2;
            iu2  = $urandom % 2;
            iw   = ($urandom % 4) != 0;
            r    = $urandom_range(0, 7);
            wv   = ($urandom % 2) && (m_busy[0][r] || m_busy[1][r] || ($urandom % 16 == 0));
            wd   = 5'(r);
            fl   = ($urandom % 40) == 0;
            cycle("rnd");
            if (n % 150 == 149) async_reset("rnd_rst");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
